// File: rtl/logic_arb_pkg.sv
// Shared defaults and enums for the round-robin bitwise logic unit arbiter.
// Operation select enum is only consumed when LOGIC_ARB_OPSEL_EN is defined.
package logic_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr.
// Produces a one-hot grant, the grant index and an any-valid flag.
module rr_picker
    import logic_arb_pkg::*;
#(
    parameter int N  = N_REQ_DEF,
    parameter int IW = $clog2(N_REQ_DEF)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            if (!o_any) begin
                w_j = (int'(i_ptr) + k) % N;
                if (i_req[w_j]) begin
                    o_grant[w_j] = 1'b1;
                    o_idx        = IW'(w_j);
                    o_any        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a single registered bitwise logic unit.
// Define LOGIC_ARB_OPSEL_EN to add per-requester req_op (AND/OR/XOR/NAND).
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]       req_x,
    input  logic [N_REQ-1:0][WIDTH-1:0]       req_y,
`ifdef LOGIC_ARB_OPSEL_EN
    input  logic [N_REQ-1:0][1:0]             req_op,
`endif
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [WIDTH-1:0]                  rsp_z,
    output logic [$clog2(N_REQ)-1:0]          rsp_id
);

    localparam int IW = $clog2(N_REQ);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0] r_z;
    logic [IW-1:0]    r_id;

    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    logic             w_any;
    logic             w_accept;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_z;

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A held result must drain in the same cycle before a new op is taken.
    assign w_accept  = w_any && !rst &&
                       ((r_state == IDLE) || rsp_ready);
    assign req_ready = w_accept ? w_grant : '0;

    assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ?
                       '0 : w_idx + IW'(1);

`ifdef LOGIC_ARB_OPSEL_EN
    op_t w_op;

    always_comb begin
        w_x  = req_x[w_idx];
        w_y  = req_y[w_idx];
        w_op = op_t'(req_op[w_idx]);
        case (w_op)
            OP_OR:   w_z = w_x | w_y;
            OP_XOR:  w_z = w_x ^ w_y;
            OP_NAND: w_z = ~(w_x & w_y);
            default: w_z = w_x & w_y;
        endcase
    end
`else
    always_comb begin
        w_x = req_x[w_idx];
        w_y = req_y[w_idx];
        w_z = w_x & w_y;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (rsp_ready) w_state_nxt = w_accept ? HOLD : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_z     <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_z   <= w_z;
                r_id  <= w_idx;
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign rsp_valid = (r_state == HOLD);
    assign rsp_z     = r_z;
    assign rsp_id    = r_id;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a reference model pushes expected
// results on request transfer; a monitor pops and compares on response transfer.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][W-1:0]  req_x = '0;
    logic [N-1:0][W-1:0]  req_y = '0;
`ifdef LOGIC_ARB_OPSEL_EN
    logic [N-1:0][1:0]    req_op = '0;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [W-1:0]         rsp_z;
    logic [1:0]           rsp_id;

    int n_vec = 0;
    int n_err = 0;

    logic [W+1:0] sb_q[$];

    logic         m_hold = 1'b0;
    int           m_ptr  = 0;

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_z;
    logic [1:0]   prev_id;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
`ifdef LOGIC_ARB_OPSEL_EN
        .req_op    (req_op),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [1:0] op);
        case (op)
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            2'b11:   return ~(x & y);
            default: return x & y;
        endcase
    endfunction

    // Reference model: expected req_ready / rsp_valid, pushes expected results.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [1:0]   op;
        int           win;
        logic         acc;
        exp_rdy = '0;
        win     = -1;
        op      = 2'b00;
        for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_ptr + k) % N])
                win = (m_ptr + k) % N;
        acc = !rst && (win >= 0) && (!m_hold || rsp_ready);
        if (acc) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            m_hold = 1'b0;
            m_ptr  = 0;
            sb_q.delete();
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_hold));
            if (acc) begin
`ifdef LOGIC_ARB_OPSEL_EN
                op = req_op[win];
`endif
                sb_q.push_back({2'(win), ref_op(req_x[win], req_y[win], op)});
                m_ptr  = (win + 1) % N;
                m_hold = 1'b1;
            end else if (m_hold && rsp_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    // Monitor: compares responses and checks stability while stalled.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_z", 32'(rsp_z), 32'(prev_z));
                chk("stall_id", 32'(rsp_id), 32'(prev_id));
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(1), 32'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_z", 32'(rsp_z), 32'(e[W-1:0]));
                    chk("rsp_id", 32'(rsp_id), 32'(e[W+1:W]));
                end
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_z     = rsp_z;
            prev_id    = rsp_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] ids [5];
        logic [1:0] hold_id;
        logic [W-1:0] hold_z;
        ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        req_x[0] = 8'hF0; req_y[0] = 8'h3C;
        req_x[1] = 8'h55; req_y[1] = 8'hFF;
        req_x[2] = 8'h3C; req_y[2] = 8'h0F;
        req_x[3] = 8'h81; req_y[3] = 8'hC3;

        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", 32'(rsp_valid), 32'(0));
        chk("rst_z", 32'(rsp_z), 32'(0));
        chk("rst_id", 32'(rsp_id), 32'(0));

        // single request from 0: F0 & 3C = 30
        req_valid = 4'b0001; rsp_ready = 1'b1;
        tick();
        req_valid = 4'b0000;
        chk("first_valid", 32'(rsp_valid), 32'(1));
        chk("first_z", 32'(rsp_z), 32'h30);
        chk("first_id", 32'(rsp_id), 32'(0));
        tick();
        chk("drain_idle", 32'(rsp_valid), 32'(0));

        // reset pointer, then full contention
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_order", 32'(rsp_id), 32'(ids[i]));
        end
        chk("rr_z3", 32'(rsp_z), 32'h30);

        // stall five cycles with everyone still requesting
        rsp_ready = 1'b0;
        tick();
        hold_id = rsp_id; hold_z = rsp_z;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rdy", 32'(req_ready), 32'(0));
            chk("stall_id_hold", 32'(rsp_id), 32'(hold_id));
            chk("stall_z_hold", 32'(rsp_z), 32'(hold_z));
        end

        // requester 2 withdraws before it is ever accepted
        req_valid = 4'b0100;
        tick(); tick();
        req_valid = 4'b0000; rsp_ready = 1'b1;
        tick();
        chk("withdraw_idle", 32'(rsp_valid), 32'(0));

        // ptr wrap: push ptr to 3, then 3 beats 0; 81&C3 = 81
        rst = 1'b1; tick(); rst = 1'b0;
        req_valid = 4'b0100;
        tick();
        chk("ptr_to3_id", 32'(rsp_id), 32'(2));
        req_valid = 4'b1001;
        tick();
        chk("wrap_id3", 32'(rsp_id), 32'(3));
        chk("wrap_z3", 32'(rsp_z), 32'h81);
        tick();
        chk("wrap_id0", 32'(rsp_id), 32'(0));
        req_valid = 4'b0000;
        tick();

        // reset while holding discards the result
        req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0000;
        chk("hold_before_rst", 32'(rsp_valid), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_hold_valid", 32'(rsp_valid), 32'(0));
        chk("rst_hold_z", 32'(rsp_z), 32'(0));
        rsp_ready = 1'b1; req_valid = 4'b1111;
        tick();
        chk("rst_ptr0", 32'(rsp_id), 32'(0));
        req_valid = 4'b0000;
        tick();

`ifdef LOGIC_ARB_OPSEL_EN
        req_x[0] = 8'hAA; req_y[0] = 8'h0F;
        req_valid = 4'b0001;
        req_op[0] = 2'b00; tick();
        chk("op_and", 32'(rsp_z), 32'h0A);
        req_op[0] = 2'b01; tick();
        chk("op_or", 32'(rsp_z), 32'hAF);
        req_op[0] = 2'b10; tick();
        chk("op_xor", 32'(rsp_z), 32'hA5);
        req_op[0] = 2'b11; tick();
        chk("op_nand", 32'(rsp_z), 32'hF5);
        req_valid = 4'b0000;
        tick();
`endif

        tick(); tick();
        chk("sb_drained", 32'(sb_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
